uart_rx_ctrl: RTL

//  Controller that configures and drains the UART receive datapath (rcv_block).

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/rx_byte_fifo.sv | 56 +++++
 rtl/uart_rx_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } rx_ctrl_state_t;

  localparam logic [1:0] CFG_ADDR_BITP  = 2'd0;
  localparam logic [1:0] CFG_ADDR_DSIZE = 2'd1;
  localparam logic [1:0] CFG_ADDR_CTRL  = 2'd2;

  localparam logic [3:0] DSIZE_5 = 4'd5;
  localparam logic [3:0] DSIZE_7 = 4'd7;
  localparam logic [3:0] DSIZE_8 = 4'd8;

  // The receiver only supports these frame widths.
  function automatic logic dsize_legal(input logic [3:0] val);
    return (val == DSIZE_5) || (val == DSIZE_7) || (val == DSIZE_8);
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte FIFO between the receive sequencer and the consumer.
// Latency: a push is visible at head/count one clock later; a pop advances head the same way.
// Backpressure: push is dropped when full unless a pop happens that cycle; pop is dropped when empty.
// Ports: clk, n_rst, push/push_data (write side), pop (read side), head, count, full, empty.
module rx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is allowed then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Configures the UART receiver, acknowledges each received byte and queues it for the consumer.
// Latency: data_ready -> byte on rd_valid/rd_data 1 clk; data_read pulses for the 1 clk after the push.
// Backpressure: a full FIFO holds the sequencer in IDLE without acking, leaving the byte in the receiver.
// Ports: clk/n_rst; cfg_we/cfg_addr/cfg_wdata register writes; bit_period/data_size/data_read to the
// receiver; rx_data/data_ready/overrun_error/framing_error from it; rd_valid/rd_data/rd_ready consumer
// handshake; fifo_count, err_sticky ([1]=overrun [0]=framing) and irq status.
// Optional: define UART_RX_ERR_CNT_EN to add saturating frm_err_cnt/ovr_err_cnt edge counters.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH         = 8,
  parameter logic [13:0] DEFAULT_BIT_PERIOD = 14'd10,
  parameter logic [3:0]  DEFAULT_DATA_SIZE  = 4'd8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_addr,
  input  logic [15:0]                   cfg_wdata,
  output logic [13:0]                   bit_period,
  output logic [3:0]                    data_size,
  output logic                          data_read,
  input  logic [7:0]                    rx_data,
  input  logic                          data_ready,
  input  logic                          overrun_error,
  input  logic                          framing_error,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    err_sticky,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0]                    frm_err_cnt,
  output logic [7:0]                    ovr_err_cnt,
`endif
  output logic                          irq
);

  rx_ctrl_state_t state;
  logic           enable;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           cfg_ctrl_we;
  logic           err_clr;
  logic           unused_wdata;

  assign unused_wdata = &{1'b0, cfg_wdata[15:14]};

  assign cfg_ctrl_we = cfg_we && (cfg_addr == CFG_ADDR_CTRL);
  assign err_clr     = cfg_ctrl_we && cfg_wdata[1];
  assign push        = (state == IDLE) && enable && data_ready && !fifo_full;
  assign pop         = rd_valid && rd_ready;
  assign rd_valid    = !fifo_empty;
  assign irq         = rd_valid || (|err_sticky);

  // Timing configuration is frozen while the receiver is running.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_period <= DEFAULT_BIT_PERIOD;
      data_size  <= DEFAULT_DATA_SIZE;
      enable     <= 1'b0;
    end else if (cfg_we) begin
      if (!enable && (cfg_addr == CFG_ADDR_BITP) && (cfg_wdata[13:0] > 14'd1))
        bit_period <= cfg_wdata[13:0];
      if (!enable && (cfg_addr == CFG_ADDR_DSIZE) && dsize_legal(cfg_wdata[3:0]))
        data_size <= cfg_wdata[3:0];
      if (cfg_addr == CFG_ADDR_CTRL)
        enable <= cfg_wdata[0];
    end
  end

  // WAIT_CLR holds off until the receiver drops data_ready, so one byte is never captured twice.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      data_read <= 1'b0;
    end else begin
      data_read <= 1'b0;
      case (state)
        IDLE: begin
          if (push) begin
            state     <= ACK;
            data_read <= 1'b1;
          end
        end
        ACK:      state <= WAIT_CLR;
        WAIT_CLR: if (!data_ready) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // A new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_sticky <= 2'b00;
    end else begin
      err_sticky[1] <= (err_sticky[1] && !err_clr) || (overrun_error && enable);
      err_sticky[0] <= (err_sticky[0] && !err_clr) || (framing_error && enable);
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic frm_q;
  logic ovr_q;
  logic frm_rise;
  logic ovr_rise;

  assign frm_rise = framing_error && !frm_q && enable;
  assign ovr_rise = overrun_error && !ovr_q && enable;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  // An edge coinciding with a clear restarts the count at 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frm_q       <= 1'b0;
      ovr_q       <= 1'b0;
      frm_err_cnt <= 8'd0;
      ovr_err_cnt <= 8'd0;
    end else begin
      frm_q <= framing_error;
      ovr_q <= overrun_error;
      if (frm_rise)     frm_err_cnt <= err_clr ? 8'd1 : sat_inc(frm_err_cnt);
      else if (err_clr) frm_err_cnt <= 8'd0;
      if (ovr_rise)     ovr_err_cnt <= err_clr ? 8'd1 : sat_inc(ovr_err_cnt);
      else if (err_clr) ovr_err_cnt <= 8'd0;
    end
  end
`endif

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data (rx_data),
    .pop       (pop),
    .head      (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
